// File: rtl/morra_cinese_pkg.sv
// Shared codes for the morra cinese referee: moves, manche results, match results, FSM states.
package morra_cinese_pkg;

    localparam logic [1:0] NO_MOVE  = 2'b00;
    localparam logic [1:0] ROCK     = 2'b01;
    localparam logic [1:0] PAPER    = 2'b10;
    localparam logic [1:0] SCISSORS = 2'b11;

    localparam logic [1:0] INVALID = 2'b00;
    localparam logic [1:0] PLAYER1 = 2'b01;
    localparam logic [1:0] PLAYER2 = 2'b10;
    localparam logic [1:0] NONE    = 2'b11;

    localparam logic [1:0] NOT_ENDED = 2'b00;
    localparam logic [1:0] P1_WINNER = 2'b01;
    localparam logic [1:0] P2_WINNER = 2'b10;
    localparam logic [1:0] DRAW      = 2'b11;

    typedef enum logic [4:0] {
        IDLE      = 5'd0,
        PLAYING   = 5'd1,
        GAME_OVER = 5'd2
    } state_e;

    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return (a == ROCK && b == SCISSORS) ||
               (a == SCISSORS && b == PAPER) ||
               (a == PAPER && b == ROCK);
    endfunction

endpackage

// File: rtl/morra_cinese_judge.sv
// Combinational judge of one manche: legality (incl. repeat-winning-move ban) and winner.
module morra_cinese_judge
    import morra_cinese_pkg::*;
(
    input  logic [1:0] p1_move_i,
    input  logic [1:0] p2_move_i,
    input  logic [1:0] last_p1_i,
    input  logic [1:0] last_p2_i,
    output logic       valid_o,
    output logic [1:0] winner_o
);

    // last_pX_i is NO_MOVE when no restriction applies, and a NO_MOVE play is already illegal
    assign valid_o = (p1_move_i != NO_MOVE) && (p2_move_i != NO_MOVE) &&
                     (p1_move_i != last_p1_i) && (p2_move_i != last_p2_i);

    always_comb begin
        winner_o = INVALID;
        if (valid_o) begin
            if (p1_move_i == p2_move_i)
                winner_o = NONE;
            else if (beats(p1_move_i, p2_move_i))
                winner_o = PLAYER1;
            else
                winner_o = PLAYER2;
        end
    end

endmodule

// File: rtl/morra_cinese.sv
// Morra cinese referee top: restart/config, manche counting and match-end FSM.
// MANCHE/PARTITA are Mealy outputs valid in the same cycle as the moves.
module morra_cinese
    import morra_cinese_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INIZIA,
    input  logic [1:0] PRIMO,
    input  logic [1:0] SECONDO,
    output logic [1:0] MANCHE,
    output logic [1:0] PARTITA,
    output logic [4:0] max_manches,
    output logic [4:0] manches_played,
    output logic [4:0] current_state,
    output logic [4:0] next_state,
    output logic       moves_are_valid,
    output logic       played_max,
    output logic       played_min,
    output logic [1:0] manche_winner,
    output logic [1:0] leading_player,
    output logic [1:0] tmp_game_winner,
    output logic [1:0] last_p1_move,
    output logic [1:0] last_p2_move
);

    state_e     state_q, state_d;
    logic [4:0] max_q, max_d;
    logic [4:0] played_q, played_d;
    logic [4:0] p1_wins_q, p1_wins_d;
    logic [4:0] p2_wins_q, p2_wins_d;
    logic [1:0] last_p1_q, last_p1_d;
    logic [1:0] last_p2_q, last_p2_d;
    logic [1:0] judge_winner;
    logic       margin_ok;
    logic       playing;

    morra_cinese_judge u_judge (
        .p1_move_i (PRIMO),
        .p2_move_i (SECONDO),
        .last_p1_i (last_p1_q),
        .last_p2_i (last_p2_q),
        .valid_o   (moves_are_valid),
        .winner_o  (judge_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            max_q     <= '0;
            played_q  <= '0;
            p1_wins_q <= '0;
            p2_wins_q <= '0;
            last_p1_q <= NO_MOVE;
            last_p2_q <= NO_MOVE;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            played_q  <= played_d;
            p1_wins_q <= p1_wins_d;
            p2_wins_q <= p2_wins_d;
            last_p1_q <= last_p1_d;
            last_p2_q <= last_p2_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        max_d          = max_q;
        played_d       = played_q;
        p1_wins_d      = p1_wins_q;
        p2_wins_d      = p2_wins_q;
        last_p1_d      = last_p1_q;
        last_p2_d      = last_p2_q;
        MANCHE         = INVALID;
        PARTITA        = NOT_ENDED;
        playing        = (state_q == PLAYING) && !INIZIA;

        if (INIZIA) begin
            max_d     = 5'({PRIMO, SECONDO}) + 5'd4;
            played_d  = '0;
            p1_wins_d = '0;
            p2_wins_d = '0;
            last_p1_d = NO_MOVE;
            last_p2_d = NO_MOVE;
            state_d   = PLAYING;
        end else if (playing) begin
            MANCHE = judge_winner;
            if (moves_are_valid) begin
                played_d = played_q + 5'd1;
                // a win bans the winner's move next manche; a draw lifts every ban
                unique case (judge_winner)
                    PLAYER1: begin
                        p1_wins_d = p1_wins_q + 5'd1;
                        last_p1_d = PRIMO;
                        last_p2_d = NO_MOVE;
                    end
                    PLAYER2: begin
                        p2_wins_d = p2_wins_q + 5'd1;
                        last_p2_d = SECONDO;
                        last_p1_d = NO_MOVE;
                    end
                    default: begin
                        last_p1_d = NO_MOVE;
                        last_p2_d = NO_MOVE;
                    end
                endcase
            end
        end

        played_max = (played_d == max_q);
        played_min = (played_d >= 5'd4);
        if (p1_wins_d > p2_wins_d)
            leading_player = P1_WINNER;
        else if (p2_wins_d > p1_wins_d)
            leading_player = P2_WINNER;
        else
            leading_player = DRAW;
        margin_ok = (p1_wins_d >= p2_wins_d + 5'd2) || (p2_wins_d >= p1_wins_d + 5'd2);

        if (playing) begin
            if ((played_min && margin_ok) || played_max)
                PARTITA = leading_player;
            if (PARTITA != NOT_ENDED)
                state_d = GAME_OVER;
        end
    end

    assign max_manches     = max_q;
    assign manches_played  = played_q;
    assign current_state   = state_q;
    assign next_state      = state_d;
    assign manche_winner   = MANCHE;
    assign tmp_game_winner = PARTITA;
    assign last_p1_move    = last_p1_q;
    assign last_p2_move    = last_p2_q;

endmodule

// File: tb/tb_morra_cinese.sv
// Directed bench for morra_cinese: expected MANCHE/PARTITA queued at drive time, checked mid-cycle.
module tb_morra_cinese;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       INIZIA;
    logic [1:0] PRIMO, SECONDO;
    logic [1:0] MANCHE, PARTITA;
    logic [4:0] max_manches, manches_played, current_state, next_state;
    logic       moves_are_valid, played_max, played_min;
    logic [1:0] manche_winner, leading_player, tmp_game_winner, last_p1_move, last_p2_move;

    localparam logic [1:0] N = 2'b00, R = 2'b01, P = 2'b10, S = 2'b11;

    int n_assert = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    morra_cinese dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .INIZIA          (INIZIA),
        .PRIMO           (PRIMO),
        .SECONDO         (SECONDO),
        .MANCHE          (MANCHE),
        .PARTITA         (PARTITA),
        .max_manches     (max_manches),
        .manches_played  (manches_played),
        .current_state   (current_state),
        .next_state      (next_state),
        .moves_are_valid (moves_are_valid),
        .played_max      (played_max),
        .played_min      (played_min),
        .manche_winner   (manche_winner),
        .leading_player  (leading_player),
        .tmp_game_winner (tmp_game_winner),
        .last_p1_move    (last_p1_move),
        .last_p2_move    (last_p2_move)
    );

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %0h/%0h expected entry", tag, MANCHE, PARTITA);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".MANCHE"}, 5'(MANCHE), 5'(e[3:2]));
            check({tag, ".PARTITA"}, 5'(PARTITA), 5'(e[1:0]));
        end
    endtask

    // called just after a rising edge; consumes exactly one cycle, leaves inputs idle
    task automatic step(input string tag, input logic ini, input logic [1:0] p1, input logic [1:0] p2,
                        input logic [1:0] em, input logic [1:0] ep);
        INIZIA  = ini;
        PRIMO   = p1;
        SECONDO = p2;
        exp_q.push_back({em, ep});
        #3;
        compare_out(tag);
        @(posedge clk);
        #1;
        INIZIA  = 1'b0;
        PRIMO   = N;
        SECONDO = N;
    endtask

    initial begin
        rst_n = 1'b0; INIZIA = 1'b0; PRIMO = P; SECONDO = R;
        #2;
        check("rst.state", current_state, 5'd0);
        check("rst.max", max_manches, 5'd0);
        check("rst.played", manches_played, 5'd0);
        check("rst.last_p1", 5'(last_p1_move), 5'd0);
        exp_q.push_back(4'b0000);
        compare_out("rst.out");
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        PRIMO = N; SECONDO = N;

        // invalid moves and carry-over of the repeat ban
        step("t1.restart", 1'b1, P, R, 2'b00, 2'b00);
        check("t1.max", max_manches, 5'd13);
        check("t1.state", current_state, 5'd1);
        step("t1.none", 1'b0, N, N, 2'b00, 2'b00);
        step("t1.p1win", 1'b0, P, R, 2'b01, 2'b00);
        step("t1.p2win", 1'b0, S, R, 2'b10, 2'b00);
        check("t1.last_p2", 5'(last_p2_move), 5'(R));
        step("t1.half", 1'b0, N, P, 2'b00, 2'b00);
        step("t1.rep1", 1'b0, R, R, 2'b00, 2'b00);
        step("t1.rep2", 1'b0, R, R, 2'b00, 2'b00);
        step("t1.rep3", 1'b0, P, R, 2'b00, 2'b00);
        check("t1.played", manches_played, 5'd2);

        // early win on a two-manche margin
        step("t2.restart", 1'b1, N, R, 2'b00, 2'b00);
        check("t2.max", max_manches, 5'd5);
        step("t2.m1", 1'b0, R, P, 2'b10, 2'b00);
        step("t2.m2", 1'b0, S, R, 2'b10, 2'b00);
        step("t2.m3", 1'b0, P, S, 2'b10, 2'b00);
        step("t2.m4", 1'b0, S, P, 2'b01, 2'b10);
        check("t2.state", current_state, 5'd2);
        step("t2.over", 1'b0, R, S, 2'b00, 2'b00);
        check("t2.state_hold", current_state, 5'd2);

        // max reached with equal wins
        step("t3.restart", 1'b1, N, N, 2'b00, 2'b00);
        check("t3.max", max_manches, 5'd4);
        step("t3.m1", 1'b0, R, S, 2'b01, 2'b00);
        step("t3.m2", 1'b0, P, S, 2'b10, 2'b00);
        step("t3.m3", 1'b0, S, P, 2'b01, 2'b00);
        step("t3.m4", 1'b0, P, S, 2'b10, 2'b11);
        check("t3.state", current_state, 5'd2);

        // a drawn manche lifts the ban
        step("t4.restart", 1'b1, S, S, 2'b00, 2'b00);
        check("t4.max", max_manches, 5'd19);
        step("t4.p1rock", 1'b0, R, S, 2'b01, 2'b00);
        step("t4.banned", 1'b0, R, R, 2'b00, 2'b00);
        step("t4.draw", 1'b0, P, P, 2'b11, 2'b00);
        check("t4.last_p1", 5'(last_p1_move), 5'd0);
        check("t4.played_a", manches_played, 5'd2);
        step("t4.rock_again", 1'b0, R, S, 2'b01, 2'b00);
        check("t4.played_b", manches_played, 5'd3);
        check("t4.last_p1b", 5'(last_p1_move), 5'(R));

        // restart mid-match
        step("t5.restart", 1'b1, 2'b01, 2'b10, 2'b00, 2'b00);
        check("t5.played", manches_played, 5'd0);
        check("t5.max", max_manches, 5'd10);
        check("t5.last_p1", 5'(last_p1_move), 5'd0);
        step("t5.m1", 1'b0, R, S, 2'b01, 2'b00);

        // async reset pulse mid-cycle
        PRIMO = P; SECONDO = R;
        exp_q.push_back(4'b0100);
        #1;
        compare_out("t6.pre");
        rst_n = 1'b0;
        exp_q.push_back(4'b0000);
        #1;
        compare_out("t6.inrst");
        check("t6.state", current_state, 5'd0);
        check("t6.played", manches_played, 5'd0);
        check("t6.max", max_manches, 5'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        PRIMO = N; SECONDO = N;
        step("t6.ignored", 1'b0, P, R, 2'b00, 2'b00);
        check("t6.idle", current_state, 5'd0);
        step("t6.restart", 1'b1, N, N, 2'b00, 2'b00);
        step("t6.play", 1'b0, P, R, 2'b01, 2'b00);
        check("t6.played_after", manches_played, 5'd1);

        if (exp_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb.drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
